// File: rtl/button_event_fifo.sv
// button_event_fifo: synchronise and debounce four game buttons, turn each
// debounced press into a colour event, and queue the events for the CPU poll
// at address 7.
// Optional feature macro: BUTTON_RELEASE_EVENT_EN (also queue release events).
module button_event_fifo #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned CNT_W           = 19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        green_button,
  input  logic        yellow_button,
  input  logic        poll,
  output logic [31:0] button_out,
  output logic        empty,
  output logic        overflow
);

  localparam int unsigned NB     = 4;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTF_W = PTR_W + 1;
`ifdef BUTTON_RELEASE_EVENT_EN
  localparam int unsigned ENTRY_W = 3;
  localparam int unsigned REQ_W   = 8;
`else
  localparam int unsigned ENTRY_W = 2;
  localparam int unsigned REQ_W   = 4;
`endif

  logic [NB-1:0]      raw;
  logic [NB-1:0]      sync1;
  logic [NB-1:0]      sync2;
  logic [NB-1:0]      db;
  logic [NB-1:0]      db_d;
  logic [CNT_W-1:0]   cnt [NB];
  logic [REQ_W-1:0]   pending;
  logic [REQ_W-1:0]   req_set;
  logic [REQ_W-1:0]   grant;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNTF_W-1:0]  count;
  logic               poll_d;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               full;

  // Bit index doubles as the colour code: red=0, blue=1, green=2, yellow=3.
  assign raw = {yellow_button, green_button, blue_button, red_button};

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: level flips after DEBOUNCE_CYCLES of disagreement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < int'(NB); i++) cnt[i] <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < int'(NB); i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Edge detect on the debounced levels; low half = presses, high half = releases.
`ifdef BUTTON_RELEASE_EVENT_EN
  assign req_set = {db_d & ~db, db & ~db_d};
`else
  assign req_set = db & ~db_d;
`endif

  // Fixed-priority pick of the lowest set pending bit; its index is the entry.
  always_comb begin
    grant      = '0;
    push_entry = '0;
    for (int i = int'(REQ_W) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant      = REQ_W'(1) << i;
        push_entry = ENTRY_W'(i);
      end
    end
  end

  // Pending events: granted bit clears, new edges set (same colour merges).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~grant) | req_set;
  end

  assign push_req = |pending;
  assign full     = (count == CNTF_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop      = ~poll & poll_d & ~empty;
  assign push_ok  = push_req & (~full | pop);

  // Poll window tracker; pop fires on the first low cycle after a window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) poll_d <= 1'b0;
    else        poll_d <= poll;
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNTF_W'(1);
        2'b01:   count <= count - CNTF_W'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  assign head = mem[rd_ptr];

  // Event word seen by the CPU: valid bit plus colour, zero when empty.
  always_comb begin
    button_out = 32'd0;
    if (!empty) begin
`ifdef BUTTON_RELEASE_EVENT_EN
      button_out = {28'd0, head[2], 1'b1, head[1:0]};
`else
      button_out = {29'd0, 1'b1, head[1:0]};
`endif
    end
  end

endmodule

// File: doc/button_event_fifo.md
Name: button_event_fifo

Overview:
- Input stage for the lw-address-7 button poll path.
- Synchronises and debounces the four game buttons, then turns each debounced press into a colour event.
- Queues events in a small FIFO so presses made while the CPU is busy are not lost.
- Presents the oldest event as the 32-bit word the CPU reads at address 7.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronised input must be stable before the debounced level changes (10 ms at 50 MHz)
DEPTH, 8, FIFO entries; must be a power of 2, at least 2
CNT_W, 19, width of each debounce counter; must hold DEBOUNCE_CYCLES

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
red_button  in  1  raw button, active-high, asynchronous
blue_button  in  1  raw button
green_button  in  1  raw button
yellow_button  in  1  raw button
poll  in  1  high while the CPU accesses address 7; may stay high for several cycles
button_out  out  32  event word: bit2 = valid, bits[1:0] = colour; all other bits 0
empty  out  1  FIFO holds no events
overflow  out  1  sticky flag: a press was dropped because the FIFO was full

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset is low:
  - FIFO is emptied; pointers and count = 0.
  - Synchronisers, debounce counters, debounced levels, pending bits and the poll delay flop are all 0.
  - Outputs: button_out = 0, empty = 1, overflow = 0.
- Colour codes: red = 00, blue = 01, green = 10, yellow = 11.
- Synchronisation: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - While the synchronised input differs from the debounced level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - Any cycle the input equals the debounced level, the counter clears.
- Press detect:
  - A 0->1 transition of a debounced level sets pending[colour].
  - A second press of the same colour while its pending bit is still set merges into that bit.
- Push arbitration:
  - Each cycle, the lowest-coded set pending bit (red highest priority) is pushed and its bit cleared.
  - At most one push per cycle; simultaneous presses therefore enqueue red, blue, green, yellow on consecutive cycles.
- Full FIFO:
  - A push with no pop in the same cycle is dropped, its pending bit is still cleared, and overflow is set.
  - overflow clears only on reset.
- Read data:
  - button_out is combinational from the FIFO head: {29'd0, 1'b1, head[1:0]} when not empty, 32'd0 when empty.
  - It is stable for the whole poll window unless a push into an empty FIFO occurs during that window.
- Pop:
  - A pop happens on the clock edge where poll is low and poll_d (poll delayed one cycle) is high, i.e. the first low cycle after a poll window, and only if the FIFO is not empty.
  - Polling an empty FIFO pops nothing.
- Push and pop on the same edge:
  - Both take effect and the count is unchanged.
  - When full, this push is accepted, not dropped.
- Latency:
  - Raw press to pending bit: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1.
  - Pending bit to visible at button_out: 1 cycle.
- Pointers wrap modulo DEPTH.
- empty = (count == 0).

Optional Feature:
BUTTON_RELEASE_EVENT_EN
- Defined:
  - A 1->0 transition of a debounced level sets a second pending bit per colour (release_pending[colour]).
  - Each FIFO entry is 3 bits wide; a release event sets bit3 of button_out.
  - Arbitration order: press bits before release bits, each group red first.
- Undefined: releases are ignored, entries are 2 bits wide, and bit3 of button_out is always 0.

Test Plan:
Run with DEBOUNCE_CYCLES=4 and DEPTH=4.
1. Reset low mid-run with 2 events queued -> button_out=0, empty=1, overflow=0 immediately, before any clock edge; FIFO still empty after release.
2. green held 10 cycles, then poll high 3 cycles and low -> button_out=32'h6 throughout the poll window; empty=1 one cycle after poll falls.
3. green held 2 cycles only (bounce) -> no event; empty stays 1.
4. All four buttons pressed in the same cycle, then four separate polls -> reads 4, 5, 6, 7 in that order.
5. Six distinct presses with no polling -> four entries kept, overflow=1; polls return the first four colours; a fifth poll returns 0.
6. FIFO full, and a press reaches the FIFO on the same edge as a pop -> count stays 4, overflow stays 0, and the new colour is read last.
